// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: base opcodes and the hazard controller state encoding.
package riscv_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic {RUN, SQUASH} hz_state_t;
endpackage

// File: rtl/hazard_src_decode.sv
// Extracts register-usage information from the instruction in IF/ID.
module hazard_src_decode
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        is_load,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);
  logic [6:0] opcode;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign rs1         = instr[19:15];
  assign rs2         = instr[24:20];
  assign unused_bits = ^{instr[31:25], instr[14:12]};

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    is_load  = 1'b0;
    rd       = 5'd0;
    case (opcode)
      OP_R:      begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; rd = instr[11:7]; end
      OP_IMM:    begin uses_rs1 = 1'b1; rd = instr[11:7]; end
      OP_LOAD:   begin uses_rs1 = 1'b1; is_load = 1'b1; rd = instr[11:7]; end
      OP_STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_JALR:   begin uses_rs1 = 1'b1; rd = instr[11:7]; end
      OP_LUI, OP_AUIPC, OP_JAL: rd = instr[11:7];
      default:   ;
    endcase
  end
endmodule

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard controller: load-use bubbles, branch squash and memory freeze.
module hazard_unit
  import riscv_pkg::*;
#(
  parameter int BRANCH_PENALTY = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] instr_id,
  input  logic        branch_taken_ex,
  input  logic        mem_busy,
  output logic        HZRDcontrol,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_write,
  output logic [7:0]  stall_count
);
  hz_state_t  state;
  logic [1:0] sq_left;
  logic [4:0] ex_rd;
  logic       ex_is_load;

  logic       uses_rs1, uses_rs2, is_load;
  logic [4:0] rd, rs1, rs2;
  logic       load_use;

  hazard_src_decode u_dec (
    .instr    (instr_id),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .is_load  (is_load),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2)
  );

  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd));

  always_comb begin
    HZRDcontrol = 1'b0;
    ifid_flush  = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    if (RESET) begin
      HZRDcontrol = 1'b1;
      ifid_flush  = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
    end else if (mem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
    end else if (branch_taken_ex || state == SQUASH) begin
      HZRDcontrol = 1'b1;
      ifid_flush  = 1'b1;
    end else if (load_use) begin
      HZRDcontrol = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= RUN;
      sq_left     <= 2'd0;
      ex_rd       <= 5'd0;
      ex_is_load  <= 1'b0;
      stall_count <= 8'd0;
    end else begin
      if (!pc_write && stall_count != 8'hFF)
        stall_count <= stall_count + 8'd1;
      if (!mem_busy) begin
        if (branch_taken_ex) begin
          if (BRANCH_PENALTY > 1) begin
            state   <= SQUASH;
            sq_left <= 2'(BRANCH_PENALTY - 1);
          end else begin
            state   <= RUN;
          end
        end else if (state == SQUASH) begin
          sq_left <= sq_left - 2'd1;
          if (sq_left == 2'd1) state <= RUN;
        end
      end
      // A bubble into ID/EX must not look like a load to the next instruction.
      if (idex_write) begin
        ex_rd      <= HZRDcontrol ? 5'd0 : rd;
        ex_is_load <= HZRDcontrol ? 1'b0 : is_load;
      end
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// Directed vector bench for hazard_unit (penalty 2 main instance, penalty 4 for squash/reset corners).
module tb_hazard_unit;
  logic        clk = 1'b0;
  logic        rst, br, mb;
  logic        rst4, br4;
  logic [31:0] instr;
  logic        hz, pcw, ifw, fl, idw;
  logic        hz4, pcw4, ifw4, fl4, idw4;
  logic [7:0]  sc, sc4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_unit #(.BRANCH_PENALTY(2)) u_dut (
    .CLK(clk), .RESET(rst), .instr_id(instr), .branch_taken_ex(br), .mem_busy(mb),
    .HZRDcontrol(hz), .pc_write(pcw), .ifid_write(ifw), .ifid_flush(fl),
    .idex_write(idw), .stall_count(sc)
  );

  hazard_unit #(.BRANCH_PENALTY(4)) u_dut4 (
    .CLK(clk), .RESET(rst4), .instr_id(instr), .branch_taken_ex(br4), .mem_busy(mb),
    .HZRDcontrol(hz4), .pc_write(pcw4), .ifid_write(ifw4), .ifid_flush(fl4),
    .idex_write(idw4), .stall_count(sc4)
  );

  // Output groups {HZRDcontrol, pc_write, ifid_write, ifid_flush, idex_write}
  localparam logic [4:0] O_RST = 5'b10011;
  localparam logic [4:0] O_RUN = 5'b01101;
  localparam logic [4:0] O_LU  = 5'b10001;
  localparam logic [4:0] O_BR  = 5'b11111;
  localparam logic [4:0] O_FRZ = 5'b00000;

  localparam logic [31:0] NOP     = 32'h00000013;
  localparam logic [31:0] LW_X5   = 32'h0000A283;
  localparam logic [31:0] ADD_X5  = 32'h00228333;
  localparam logic [31:0] LW_X0   = 32'h0000A003;
  localparam logic [31:0] ADD_X0  = 32'h00000333;
  localparam logic [31:0] LUI_X5  = 32'h000012B7;
  localparam logic [31:0] JAL_X5  = 32'h000282EF;
  localparam logic [31:0] SW_X5   = 32'h0050A023;
  localparam logic [31:0] ADDI_X5 = 32'h00128393;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        br;
    logic        mb;
    logic [4:0]  outs;
    logic [7:0]  sc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [31:0] i, input logic b, input logic m,
                     input logic [4:0] o, input logic [7:0] s);
    vec_t v;
    v.rst = r; v.instr = i; v.br = b; v.mb = m; v.outs = o; v.sc = s;
    vecs.push_back(v);
  endtask

  initial begin
    // reset / load-use / no-false-stall
    add(1, NOP,     0, 0, O_RST, 0);
    add(0, LW_X5,   0, 0, O_RUN, 0);
    add(0, ADD_X5,  0, 0, O_LU,  0);
    add(0, ADD_X5,  0, 0, O_RUN, 1);
    add(0, LW_X0,   0, 0, O_RUN, 1);
    add(0, ADD_X0,  0, 0, O_RUN, 1);
    add(0, LW_X5,   0, 0, O_RUN, 1);
    add(0, LUI_X5,  0, 0, O_RUN, 1);
    add(0, LW_X5,   0, 0, O_RUN, 1);
    add(0, JAL_X5,  0, 0, O_RUN, 1);
    add(0, LW_X5,   0, 0, O_RUN, 1);
    add(0, SW_X5,   0, 0, O_LU,  1);
    add(0, SW_X5,   0, 0, O_RUN, 2);
    // freeze over a pending load-use
    add(1, NOP,     0, 0, O_RST, 2);
    add(0, LW_X5,   0, 0, O_RUN, 0);
    add(0, ADDI_X5, 0, 1, O_FRZ, 0);
    add(0, ADDI_X5, 0, 1, O_FRZ, 1);
    add(0, ADDI_X5, 0, 1, O_FRZ, 2);
    add(0, ADDI_X5, 0, 0, O_LU,  3);
    add(0, ADDI_X5, 0, 0, O_RUN, 4);
    // branch penalty 2
    add(0, NOP,     1, 0, O_BR,  4);
    add(0, NOP,     0, 0, O_BR,  4);
    add(0, NOP,     0, 0, O_RUN, 4);
    // branch masked by freeze, freeze inside squash
    add(0, NOP,     1, 1, O_FRZ, 4);
    add(0, NOP,     1, 0, O_BR,  5);
    add(0, NOP,     0, 1, O_FRZ, 5);
    add(0, NOP,     0, 0, O_BR,  6);
    add(0, NOP,     0, 0, O_RUN, 6);
    // reload in squash
    add(0, NOP,     1, 0, O_BR,  6);
    add(0, NOP,     1, 0, O_BR,  6);
    add(0, NOP,     0, 0, O_BR,  6);
    add(0, NOP,     0, 0, O_RUN, 6);
    // branch outranks load-use and bubbles the loaded shadow
    add(0, LW_X5,   0, 0, O_RUN, 6);
    add(0, ADD_X5,  1, 0, O_BR,  6);
    add(0, ADD_X5,  0, 0, O_BR,  6);
    add(0, ADD_X5,  0, 0, O_RUN, 6);

    rst = 1; br = 0; mb = 0; instr = NOP; rst4 = 1; br4 = 0;
    @(negedge clk);
    @(negedge clk);

    foreach (vecs[k]) begin
      rst = vecs[k].rst; instr = vecs[k].instr; br = vecs[k].br; mb = vecs[k].mb;
      #1;
      check($sformatf("vec%0d", k), {hz, pcw, ifw, fl, idw, sc}, {vecs[k].outs, vecs[k].sc});
      @(negedge clk);
    end

    // saturation
    rst = 0; br = 0; instr = NOP; mb = 1;
    for (int i = 0; i < 300; i++) @(negedge clk);
    #1;
    check("saturate", {5'd0, sc}, {5'd0, 8'd255});
    mb = 0;

    // penalty 4 instance: N squash cycles, then reset mid-squash
    rst4 = 1;
    @(negedge clk);
    rst4 = 0; mb = 1;
    @(negedge clk);
    @(negedge clk);
    mb = 0; #1;
    check("p4_freeze_cnt", {hz4, pcw4, ifw4, fl4, idw4, sc4}, {O_RUN, 8'd2});
    br4 = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("p4_sq%0d", i), {hz4, pcw4, ifw4, fl4, idw4, sc4},
            {(i < 4) ? O_BR : O_RUN, 8'd2});
      @(negedge clk);
      br4 = 0;
    end
    br4 = 1;
    @(negedge clk);
    br4 = 0; rst4 = 1; #1;
    check("p4_rst_sq2", {hz4, pcw4, ifw4, fl4, idw4, sc4}, {O_RST, 8'd2});
    @(negedge clk);
    rst4 = 0; #1;
    check("p4_after_rst", {hz4, pcw4, ifw4, fl4, idw4, sc4}, {O_RUN, 8'd0});
    @(negedge clk);
    #1;
    check("p4_still_run", {hz4, pcw4, ifw4, fl4, idw4, sc4}, {O_RUN, 8'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
